// File: rtl/pipeline_pkg.sv
// pipeline_pkg: widths, control-bundle bit positions and shared helpers used
// by the pipeline-register stages (ID/EX today, EX/MEM and MEM/WB later).
// No ports; imported with `import pipeline_pkg::*;`.
package pipeline_pkg;

  localparam int DATA_W      = 32;
  localparam int REG_W       = 5;
  localparam int CTRL_W      = 10;
  localparam int STALL_CNT_W = 16;

  // Control bundle layout, MSB first:
  // {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp[3:0]}
  localparam int CTRL_REGWRITE  = 9;
  localparam int CTRL_MEMREAD   = 8;
  localparam int CTRL_MEMWRITE  = 7;
  localparam int CTRL_MEMTOREG  = 6;
  localparam int CTRL_ALUSRC    = 5;
  localparam int CTRL_REGDST    = 4;
  localparam int CTRL_ALUOP_LSB = 0;

  typedef logic [DATA_W-1:0] dataWord_t;
  typedef logic [REG_W-1:0]  regIdx_t;
  typedef logic [CTRL_W-1:0] ctrlWord_t;

  // Register-file read with write-back bypass. The register file and this
  // stage update on the same edge, so a write in flight must be forwarded
  // here or the captured operand would be stale. $zero always reads 0.
  function automatic dataWord_t selectOperand(
    input regIdx_t   idx,
    input dataWord_t rfData,
    input logic      wbRegWrite,
    input regIdx_t   wbWriteReg,
    input dataWord_t wbWriteData
  );
    if (idx == '0)
      return '0;
    else if (wbRegWrite && (wbWriteReg == idx))
      return wbWriteData;
    else
      return rfData;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_if: bundle between the decode front end and the ID/EX register.
//   master : decode side / test driver (drives id_*, rf_*, wb_*, flush, ex_hold)
//   slave  : the ID/EX stage (drives ex_*, stall, stall_count)
interface id_ex_if;
  import pipeline_pkg::*;

  logic                   id_valid;
  regIdx_t                id_rs, id_rt, id_rd;
  logic                   id_uses_rs, id_uses_rt;
  dataWord_t              id_imm;
  ctrlWord_t              id_ctrl;
  dataWord_t              rf_data1, rf_data2;
  logic                   wb_regwrite;
  regIdx_t                wb_writereg;
  dataWord_t              wb_writedata;
  logic                   flush;
  logic                   ex_hold;

  logic                   ex_valid;
  regIdx_t                ex_rs, ex_rt, ex_rd, ex_dest;
  dataWord_t              ex_imm, ex_data1, ex_data2;
  ctrlWord_t              ex_ctrl;
  logic                   stall;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_imm, id_ctrl,
           rf_data1, rf_data2, wb_regwrite, wb_writereg, wb_writedata, flush, ex_hold,
    input  ex_valid, ex_rs, ex_rt, ex_rd, ex_dest, ex_imm, ex_data1, ex_data2, ex_ctrl,
           stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_imm, id_ctrl,
           rf_data1, rf_data2, wb_regwrite, wb_writereg, wb_writedata, flush, ex_hold,
    output ex_valid, ex_rs, ex_rt, ex_rd, ex_dest, ex_imm, ex_data1, ex_data2, ex_ctrl,
           stall, stall_count
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: combinational load-use detector.
//   exValid/exMemRead/exRt : instruction currently in EX
//   idValid/idUses*/idRs/idRt : instruction currently in decode
//   hazard : decode reads the register a load in EX has yet to produce
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic    exValid,
  input  logic    exMemRead,
  input  regIdx_t exRt,
  input  logic    idValid,
  input  logic    idUsesRs,
  input  logic    idUsesRt,
  input  regIdx_t idRs,
  input  regIdx_t idRt,
  output logic    hazard
);

  logic rsMatch, rtMatch;

  assign rsMatch = idUsesRs && (idRs == exRt);
  assign rtMatch = idUsesRt && (idRt == exRt);

  // A load targeting $zero produces nothing to wait for.
  assign hazard = exValid && exMemRead && (exRt != '0) && idValid && (rsMatch || rtMatch);

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with write-back bypass, load-use
// bubble insertion, branch flush and execute hold.
//   Clk   : clock, all updates on posedge
//   reset : asynchronous active-low clear
//   bus   : id_ex_if.slave (decode inputs in, ex_* contents, stall and
//           stall_count out)
module id_ex_stage
  import pipeline_pkg::*;
(
  input logic     Clk,
  input logic     reset,
  id_ex_if.slave  bus
);

  logic                   exValidReg;
  regIdx_t                exRsReg, exRtReg, exRdReg, exDestReg;
  dataWord_t              exImmReg, exData1Reg, exData2Reg;
  ctrlWord_t              exCtrlReg;
  logic [STALL_CNT_W-1:0] stallCountReg;

  logic      hazard;
  dataWord_t op1, op2;

  hazard_detect hazardDetectInst (
    .exValid   (exValidReg),
    .exMemRead (exCtrlReg[CTRL_MEMREAD]),
    .exRt      (exRtReg),
    .idValid   (bus.id_valid),
    .idUsesRs  (bus.id_uses_rs),
    .idUsesRt  (bus.id_uses_rt),
    .idRs      (bus.id_rs),
    .idRt      (bus.id_rt),
    .hazard    (hazard)
  );

  assign op1 = selectOperand(bus.id_rs, bus.rf_data1, bus.wb_regwrite, bus.wb_writereg, bus.wb_writedata);
  assign op2 = selectOperand(bus.id_rt, bus.rf_data2, bus.wb_regwrite, bus.wb_writereg, bus.wb_writedata);

  // A taken branch kills the decode slot, so a hazard on it must not stall.
  assign bus.stall = bus.ex_hold || (hazard && !bus.flush);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      exValidReg    <= 1'b0;
      exRsReg       <= '0;
      exRtReg       <= '0;
      exRdReg       <= '0;
      exDestReg     <= '0;
      exImmReg      <= '0;
      exData1Reg    <= '0;
      exData2Reg    <= '0;
      exCtrlReg     <= '0;
      stallCountReg <= '0;
    end else if (bus.flush || (!bus.ex_hold && hazard)) begin
      // Bubble: all-zero control guarantees no register or memory write.
      exValidReg <= 1'b0;
      exRsReg    <= '0;
      exRtReg    <= '0;
      exRdReg    <= '0;
      exDestReg  <= '0;
      exImmReg   <= '0;
      exData1Reg <= '0;
      exData2Reg <= '0;
      exCtrlReg  <= '0;
      if (!bus.flush && (stallCountReg != {STALL_CNT_W{1'b1}}))
        stallCountReg <= stallCountReg + 1'b1;
    end else if (!bus.ex_hold) begin
      exValidReg <= bus.id_valid;
      exRsReg    <= bus.id_rs;
      exRtReg    <= bus.id_rt;
      exRdReg    <= bus.id_rd;
      exDestReg  <= bus.id_ctrl[CTRL_REGDST] ? bus.id_rd : bus.id_rt;
      exImmReg   <= bus.id_imm;
      exData1Reg <= op1;
      exData2Reg <= op2;
      exCtrlReg  <= bus.id_valid ? bus.id_ctrl : '0;
    end
    // ex_hold without flush: every field keeps its value.
  end

  assign bus.ex_valid    = exValidReg;
  assign bus.ex_rs       = exRsReg;
  assign bus.ex_rt       = exRtReg;
  assign bus.ex_rd       = exRdReg;
  assign bus.ex_dest     = exDestReg;
  assign bus.ex_imm      = exImmReg;
  assign bus.ex_data1    = exData1Reg;
  assign bus.ex_data2    = exData2Reg;
  assign bus.ex_ctrl     = exCtrlReg;
  assign bus.stall_count = stallCountReg;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  localparam logic [9:0] CTRL_LW  = 10'h360; // RegWrite MemRead MemToReg ALUSrc
  localparam logic [9:0] CTRL_ADD = 10'h212; // RegWrite RegDst ALUOp=0010

  logic Clk = 1'b0;
  logic reset;
  int   checkCount = 0;
  int   errorCount = 0;

  id_ex_if bus();

  id_ex_stage dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("check %s: %h ok", tag, got);
    end
  endtask

  task automatic stepCycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic setIdle();
    bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
    bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0; bus.id_imm = '0; bus.id_ctrl = '0;
    bus.rf_data1 = '0; bus.rf_data2 = '0;
    bus.wb_regwrite = 1'b0; bus.wb_writereg = '0; bus.wb_writedata = '0;
    bus.flush = 1'b0; bus.ex_hold = 1'b0;
  endtask

  task automatic setInstr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic usesRs, input logic usesRt, input logic [31:0] imm,
                          input logic [9:0] ctrl, input logic [31:0] d1, input logic [31:0] d2);
    bus.id_valid = 1'b1; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_uses_rs = usesRs; bus.id_uses_rt = usesRt; bus.id_imm = imm; bus.id_ctrl = ctrl;
    bus.rf_data1 = d1; bus.rf_data2 = d2;
  endtask

  // lw $10 enters EX, then a dependent add (rs=10) sits in decode:
  // one bubble, then the add is captured.
  task automatic doLoadUse();
    setInstr(5'd1, 5'd10, 5'd0, 1'b1, 1'b0, 32'h4, CTRL_LW, 32'h100, 32'h0);
    stepCycle();
    setInstr(5'd10, 5'd2, 5'd11, 1'b1, 1'b1, 32'h0, CTRL_ADD, 32'h5, 32'h6);
    stepCycle();
    stepCycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    setIdle();
    reset = 1'b0;
    // Reset held with active inputs: nothing captured.
    setInstr(5'd8, 5'd4, 5'd3, 1'b1, 1'b1, 32'h7, CTRL_ADD, 32'h1, 32'h2);
    stepCycle();
    stepCycle();
    checkVal("rst_ex_valid", 32'(bus.ex_valid), 32'h0);
    checkVal("rst_ex_ctrl", 32'(bus.ex_ctrl), 32'h0);
    checkVal("rst_ex_data1", bus.ex_data1, 32'h0);
    checkVal("rst_ex_imm", bus.ex_imm, 32'h0);
    checkVal("rst_stall_count", 32'(bus.stall_count), 32'h0);
    checkVal("rst_stall_lo", 32'(bus.stall), 32'h0);
    bus.ex_hold = 1'b1; #1;
    checkVal("rst_stall_hold", 32'(bus.stall), 32'h1);
    bus.ex_hold = 1'b0;

    // Release mid-cycle; first capture on the next edge.
    #1 reset = 1'b1;
    stepCycle();
    checkVal("cap_ex_valid", 32'(bus.ex_valid), 32'h1);
    checkVal("cap_ex_data1", bus.ex_data1, 32'h1);
    checkVal("cap_ex_data2", bus.ex_data2, 32'h2);
    checkVal("cap_ex_dest_rd", 32'(bus.ex_dest), 32'h3);
    checkVal("cap_ex_ctrl", 32'(bus.ex_ctrl), 32'(CTRL_ADD));
    checkVal("cap_ex_imm", bus.ex_imm, 32'h7);

    // Write-back bypass on rs; rt unaffected.
    setInstr(5'd9, 5'd4, 5'd3, 1'b1, 1'b1, 32'h0, CTRL_ADD, 32'h2, 32'h7);
    bus.wb_regwrite = 1'b1; bus.wb_writereg = 5'd9; bus.wb_writedata = 32'h55;
    stepCycle();
    checkVal("byp_rs_data1", bus.ex_data1, 32'h55);
    checkVal("byp_rt_nomatch", bus.ex_data2, 32'h7);
    // Bypass on rt.
    bus.id_rs = 5'd6; bus.id_rt = 5'd5; bus.wb_writereg = 5'd5; bus.wb_writedata = 32'hAA;
    stepCycle();
    checkVal("byp_rt_data2", bus.ex_data2, 32'hAA);
    checkVal("byp_rs_nomatch", bus.ex_data1, 32'h2);
    // $zero never bypassed.
    bus.id_rs = 5'd0; bus.wb_writereg = 5'd0; bus.wb_writedata = 32'h55;
    stepCycle();
    checkVal("byp_zero_data1", bus.ex_data1, 32'h0);
    bus.wb_regwrite = 1'b0;

    // Load-use: one bubble, then the add.
    setInstr(5'd1, 5'd10, 5'd0, 1'b1, 1'b0, 32'h4, CTRL_LW, 32'h100, 32'h0);
    stepCycle();
    checkVal("lw_ex_ctrl", 32'(bus.ex_ctrl), 32'(CTRL_LW));
    checkVal("lw_ex_dest_rt", 32'(bus.ex_dest), 32'd10);
    setInstr(5'd10, 5'd2, 5'd11, 1'b1, 1'b1, 32'h0, CTRL_ADD, 32'h5, 32'h6);
    #1;
    checkVal("lu_stall", 32'(bus.stall), 32'h1);
    stepCycle();
    checkVal("lu_bubble_valid", 32'(bus.ex_valid), 32'h0);
    checkVal("lu_bubble_ctrl", 32'(bus.ex_ctrl), 32'h0);
    checkVal("lu_stall_count", 32'(bus.stall_count), 32'h1);
    checkVal("lu_stall_drop", 32'(bus.stall), 32'h0);
    stepCycle();
    checkVal("lu_add_valid", 32'(bus.ex_valid), 32'h1);
    checkVal("lu_add_rs", 32'(bus.ex_rs), 32'd10);
    checkVal("lu_add_dest", 32'(bus.ex_dest), 32'd11);
    checkVal("lu_add_ctrl", 32'(bus.ex_ctrl), 32'(CTRL_ADD));

    // Load in EX, decode does not actually read rs=10: no stall.
    setInstr(5'd1, 5'd10, 5'd0, 1'b1, 1'b0, 32'h4, CTRL_LW, 32'h100, 32'h0);
    stepCycle();
    setInstr(5'd10, 5'd3, 5'd12, 1'b0, 1'b1, 32'h0, CTRL_ADD, 32'h5, 32'h6);
    #1;
    checkVal("nouse_stall", 32'(bus.stall), 32'h0);
    stepCycle();
    checkVal("nouse_valid", 32'(bus.ex_valid), 32'h1);
    checkVal("nouse_count", 32'(bus.stall_count), 32'h1);

    // Flush with hazard: flush wins, no stall, count unchanged.
    setInstr(5'd1, 5'd10, 5'd0, 1'b1, 1'b0, 32'h4, CTRL_LW, 32'h100, 32'h0);
    stepCycle();
    setInstr(5'd10, 5'd2, 5'd11, 1'b1, 1'b1, 32'h0, CTRL_ADD, 32'h5, 32'h6);
    bus.flush = 1'b1;
    #1;
    checkVal("flhz_stall", 32'(bus.stall), 32'h0);
    stepCycle();
    checkVal("flhz_valid", 32'(bus.ex_valid), 32'h0);
    checkVal("flhz_ctrl", 32'(bus.ex_ctrl), 32'h0);
    checkVal("flhz_count", 32'(bus.stall_count), 32'h1);
    bus.flush = 1'b0;
    // Flush with hold: bubble still loaded.
    setInstr(5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 32'h9, CTRL_ADD, 32'h11, 32'h22);
    stepCycle();
    checkVal("flho_pre_valid", 32'(bus.ex_valid), 32'h1);
    bus.flush = 1'b1; bus.ex_hold = 1'b1;
    #1;
    checkVal("flho_stall", 32'(bus.stall), 32'h1);
    stepCycle();
    checkVal("flho_valid", 32'(bus.ex_valid), 32'h0);
    checkVal("flho_data1", bus.ex_data1, 32'h0);
    bus.flush = 1'b0; bus.ex_hold = 1'b0;

    // Hold for three cycles with changing decode inputs.
    setInstr(5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 32'h10, CTRL_ADD, 32'h1234, 32'h22);
    stepCycle();
    bus.ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setInstr(5'(7 + i), 5'(13 + i), 5'(20 + i), 1'b1, 1'b1, 32'(32'h40 + i), CTRL_LW,
               32'(32'h500 + i), 32'(32'h600 + i));
      #1;
      checkVal("hold_stall", 32'(bus.stall), 32'h1);
      stepCycle();
      checkVal("hold_data1", bus.ex_data1, 32'h1234);
      checkVal("hold_imm", bus.ex_imm, 32'h10);
      checkVal("hold_ctrl", 32'(bus.ex_ctrl), 32'(CTRL_ADD));
    end
    bus.ex_hold = 1'b0;
    setInstr(5'd6, 5'd7, 5'd8, 1'b1, 1'b1, 32'h20, CTRL_ADD, 32'h99, 32'h88);
    stepCycle();
    checkVal("hold_rel_data1", bus.ex_data1, 32'h99);
    checkVal("hold_rel_imm", bus.ex_imm, 32'h20);

    // Invalid decode slot: control forced to zero.
    setInstr(5'd6, 5'd7, 5'd8, 1'b1, 1'b1, 32'h30, CTRL_ADD, 32'h99, 32'h88);
    bus.id_valid = 1'b0;
    stepCycle();
    checkVal("inval_valid", 32'(bus.ex_valid), 32'h0);
    checkVal("inval_ctrl", 32'(bus.ex_ctrl), 32'h0);
    checkVal("inval_imm", bus.ex_imm, 32'h30);

    // Saturation: preload near the top, then two more bubbles.
    force dut.stallCountReg = 16'hFFFD;
    #1;
    release dut.stallCountReg;
    doLoadUse();
    checkVal("sat_fffe", 32'(bus.stall_count), 32'hFFFE);
    doLoadUse();
    checkVal("sat_ffff", 32'(bus.stall_count), 32'hFFFF);
    doLoadUse();
    checkVal("sat_hold", 32'(bus.stall_count), 32'hFFFF);

    // Asynchronous reset between edges.
    setInstr(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 32'h1, CTRL_ADD, 32'h33, 32'h44);
    stepCycle();
    checkVal("arst_pre_valid", 32'(bus.ex_valid), 32'h1);
    #1 reset = 1'b0;
    #1;
    checkVal("arst_valid", 32'(bus.ex_valid), 32'h0);
    checkVal("arst_data1", bus.ex_data1, 32'h0);
    checkVal("arst_count", 32'(bus.stall_count), 32'h0);
    #1 reset = 1'b1;
    setInstr(5'd8, 5'd4, 5'd3, 1'b1, 1'b1, 32'h0, CTRL_ADD, 32'h77, 32'h0);
    #1;
    checkVal("arst_nocap", 32'(bus.ex_valid), 32'h0);
    stepCycle();
    checkVal("arst_cap_data1", bus.ex_data1, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the MIPS pipeline, sitting directly downstream of the register file. Each cycle it captures the decoded instruction, the register-file read data (with write-back bypass applied), the immediate and the control bundle, and presents them to the execute stage. It also detects load-use hazards, inserts one-cycle bubbles, drives the front-end stall, and honours branch flush and execute hold.

## Interface
- DATA_W, 32, datapath width
- REG_W, 5, register index width
- CTRL_W, 10, control bundle width: {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp[3:0]}, MSB first
- Clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; asserting it (0) clears all state immediately
- id_valid  in  1  decode slot holds a real instruction
- id_rs, id_rt, id_rd  in  REG_W  decoded register indices
- id_uses_rs, id_uses_rt  in  1  instruction actually reads rs / rt
- id_imm  in  DATA_W  sign-extended immediate
- id_ctrl  in  CTRL_W  decoded control bundle
- rf_data1, rf_data2  in  DATA_W  register-file read data for rs / rt
- wb_regwrite  in  1; wb_writereg  in  REG_W; wb_writedata  in  DATA_W  write-back port, same signals driving the register file
- flush  in  1  branch taken in EX; kill the decode slot
- ex_hold  in  1  execute stage cannot accept; freeze this register
- ex_valid  out  1; ex_rs, ex_rt, ex_rd, ex_dest  out  REG_W; ex_imm, ex_data1, ex_data2  out  DATA_W; ex_ctrl  out  CTRL_W  registered stage contents
- stall  out  1  hold PC and IF/ID register this cycle
- stall_count  out  16  saturating count of inserted load-use bubbles

## Operation
- Operand select (combinational, before capture): op1 = 0 if id_rs==0; else wb_writedata if wb_regwrite & wb_writereg==id_rs; else rf_data1. op2 likewise with id_rt/rf_data2.
- Dest select at capture: ex_dest = id_ctrl.RegDst ? id_rd : id_rt.
- Hazard = ex_valid & ex_ctrl.MemRead & ex_rt!=0 & id_valid & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- stall = ex_hold | (hazard & ~flush), combinational.
- Per-edge update, priority highest first:
  - flush: load bubble (ex_valid=0, ex_ctrl=0, all other fields 0).
  - ex_hold: keep all fields unchanged.
  - hazard: load bubble; stall_count += 1, saturating at 16'hFFFF.
  - otherwise: capture ex_valid=id_valid, fields, op1/op2; if id_valid=0, ex_ctrl is forced to 0.
- A bubble never writes registers or memory: ex_ctrl all-zero.

## Timing
- Reset (reset=0): all outputs 0, stall_count 0; stall = ex_hold during and after reset.
- Latency: decode inputs visible on ex_* one cycle after capture edge.
- Load-use: exactly one bubble per dependent instruction; hazard deasserts the cycle after the bubble (ex_valid=0) and the instruction is captured on the next edge.
- Bypass is same-cycle: a write-back on edge N is reflected in data captured on edge N even though the register file updates on the same edge.
- flush & ex_hold together: flush wins, bubble loaded.
- flush & hazard together: flush wins, stall deasserted, stall_count not incremented.
- Reset asserted mid-operation: contents cleared asynchronously, no partial capture on release; first capture on first posedge with reset=1.

## Structure
- Shared package pipeline_pkg: DATA_W, REG_W, CTRL_W, control bit-index constants (CTRL_REGWRITE, CTRL_MEMREAD, CTRL_MEMWRITE, CTRL_MEMTOREG, CTRL_ALUSRC, CTRL_REGDST, CTRL_ALUOP_LSB); reused by EX/MEM and MEM/WB stages.
- One sub-module: hazard_detect, purely combinational load-use compare producing hazard; also reused by future forwarding work.

## Test plan
- Reset: hold reset=0 with active inputs -> all ex_* 0, stall_count 0; release, id_valid=1, rs=8, rf_data1=1 -> next cycle ex_data1=1, ex_valid=1.
- Bypass: id_rs=9, rf_data1=2, wb_regwrite=1, wb_writereg=9, wb_writedata=0x55 -> ex_data1=0x55; same with wb_writereg=0 and id_rs=0 -> ex_data1=0.
- Load-use: lw rt=10 in EX, next add rs=10 -> stall=1 one cycle, bubble (ex_valid=0, ex_ctrl=0), add captured following cycle, stall_count=1; with id_uses_rs=0 -> no stall.
- Flush priority: hazard and flush same cycle -> stall=0, bubble, stall_count unchanged; flush with ex_hold=1 -> bubble loaded.
- Hold: ex_hold=1 for 3 cycles with changing id inputs -> ex_* unchanged, stall=1 each cycle; release -> current id inputs captured.
- Saturation and async reset: force 65536 bubbles -> stall_count stays 0xFFFF; drop reset mid-cycle -> outputs 0 before next edge.
